status_flag_unit: RTL

STATUS_FLAG_UNIT -- requirements
Module: status_flag_unit

---
 rtl/status_flag_unit_pkg.sv | 43 ++++
 rtl/status_flag_unit_if.sv | 30 +++
 rtl/status_flag_unit_nor_gate_4_inputs.sv | 19 +
 rtl/status_flag_unit.sv | 103 ++++++++++
 4 files changed

// File: rtl/status_flag_unit_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : status_flag_unit_pkg
// Purpose  : Shared CPU constants for the status flag unit: FSM states,
//            branch-condition codes and the condition evaluation helper.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package status_flag_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [2:0] COND_ALWAYS = 3'b000;
  localparam logic [2:0] COND_Z      = 3'b001;
  localparam logic [2:0] COND_NZ     = 3'b010;
  localparam logic [2:0] COND_C      = 3'b011;
  localparam logic [2:0] COND_NC     = 3'b100;
  localparam logic [2:0] COND_N      = 3'b101;
  localparam logic [2:0] COND_NN     = 3'b110;
  localparam logic [2:0] COND_NEVER  = 3'b111;

  // Maps a branch-condition code onto the held Z/C/N flags.
  function automatic logic cond_eval(input logic [2:0] sel, input logic z,
                                     input logic c, input logic n);
    logic result;
    case (sel)
      COND_ALWAYS: result = 1'b1;
      COND_Z:      result = z;
      COND_NZ:     result = ~z;
      COND_C:      result = c;
      COND_NC:     result = ~c;
      COND_N:      result = n;
      COND_NN:     result = ~n;
      default:     result = 1'b0;
    endcase
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/status_flag_unit_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : status_flag_unit_if
// Purpose  : ALU result-nibble stream, condition select and flag outputs.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface status_flag_unit_if;
  logic       Start;
  logic       NibbleValid;
  logic [3:0] Nibble;
  logic       CarryIn;
  logic [2:0] CondSel;
  logic       Busy;
  logic       Done;
  logic       ZeroFlag;
  logic       CarryFlag;
  logic       NegFlag;
  logic       CondTrue;

  modport master (
    output Start, NibbleValid, Nibble, CarryIn, CondSel,
    input  Busy, Done, ZeroFlag, CarryFlag, NegFlag, CondTrue
  );

  modport slave (
    input  Start, NibbleValid, Nibble, CarryIn, CondSel,
    output Busy, Done, ZeroFlag, CarryFlag, NegFlag, CondTrue
  );
endinterface
`default_nettype wire

// File: rtl/status_flag_unit_nor_gate_4_inputs.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : nor_gate_4_inputs
// Purpose  : 4-input NOR with per-input inversion bubbles; high when every
//            (optionally inverted) input bit is 0.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module nor_gate_4_inputs #(
  parameter logic [3:0] BubblesMask = 4'h0
) (
  input  logic [3:0] in_bits,
  output logic       out_bit
);

  // Bubble on bit i inverts that input before the NOR.
  assign out_bit = ~|(in_bits ^ BubblesMask);

endmodule
`default_nettype wire

// File: rtl/status_flag_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : status_flag_unit
// Purpose  : Accumulates Z/C/N flags over a multi-nibble ALU result and
//            evaluates a branch condition against the held flags.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module status_flag_unit
  import status_flag_unit_pkg::*;
#(
  parameter int         NrOfNibbles = 4,
  parameter logic [3:0] BubblesMask = 4'h0
) (
  input  logic               GlobalClock,
  input  logic               Reset,
  status_flag_unit_if.slave  bus
);

  // Index of the final nibble; the counter never runs past it.
  localparam logic [2:0] LastIndex = 3'(NrOfNibbles - 1);

  state_t     state, state_next;
  logic [2:0] count, count_next;
  logic       acc, acc_next;
  logic       zero_flag, zero_next;
  logic       carry_flag, carry_next;
  logic       neg_flag, neg_next;
  logic       nibble_zero;

  nor_gate_4_inputs #(
    .BubblesMask (BubblesMask)
  ) u_nibble_zero (
    .in_bits (bus.Nibble),
    .out_bit (nibble_zero)
  );

  // Next-state and flag-update decisions; everything holds by default.
  always_comb begin
    state_next = state;
    count_next = count;
    acc_next   = acc;
    zero_next  = zero_flag;
    carry_next = carry_flag;
    neg_next   = neg_flag;
    case (state)
      ST_IDLE: begin
        if (bus.Start) begin
          state_next = ST_ACCUM;
          count_next = 3'd0;
          acc_next   = 1'b1;
        end
      end
      ST_ACCUM: begin
        if (bus.NibbleValid) begin
          acc_next   = acc & nibble_zero;
          count_next = count + 3'd1;
          if (count == LastIndex) begin
            // Final nibble: publish flags and park the counter at 0.
            state_next = ST_DONE;
            count_next = 3'd0;
            zero_next  = acc & nibble_zero;
            carry_next = bus.CarryIn;
            neg_next   = bus.Nibble[3];
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // All state registers; reset discards any partial operation.
  always_ff @(posedge GlobalClock) begin
    if (Reset) begin
      state      <= ST_IDLE;
      count      <= 3'd0;
      acc        <= 1'b1;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
      neg_flag   <= 1'b0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      acc        <= acc_next;
      zero_flag  <= zero_next;
      carry_flag <= carry_next;
      neg_flag   <= neg_next;
    end
  end

  assign bus.Busy      = (state == ST_ACCUM);
  assign bus.Done      = (state == ST_DONE);
  assign bus.ZeroFlag  = zero_flag;
  assign bus.CarryFlag = carry_flag;
  assign bus.NegFlag   = neg_flag;
  assign bus.CondTrue  = cond_eval(bus.CondSel, zero_flag, carry_flag, neg_flag);

endmodule
`default_nettype wire
